// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// Memory-side responder for an SRAM-style CPU port. Requests decode either to
// an on-chip word RAM (2^ADDR_W x 32 bit) or to a small MMIO window selected
// by sram_addr[31:16] == MMIO_HI. Read data is registered and appears one
// cycle after the request edge. On write cycles the returned word is the
// merged post-write value (write-first).
//
// MMIO offsets (sram_addr[15:0]):
//   16'hF000 LED     : 16-bit read/write, byte enables [1:0]
//   16'hE000 TIMER   : free-running 32-bit counter (only with SRAM_RESP_TIMER_EN)
//   16'hE004 SCRATCH : 32-bit read/write
//   others           : read 0, writes ignored
//
// Build option:
//   SRAM_RESP_TIMER_EN  defined   -> TIMER implemented
//                       undefined -> no counter; 16'hE000 behaves as unmapped
//
// Ports:
//   clk        in   1   clock, rising edge
//   resetn     in   1   asynchronous active-low reset
//   sram_en    in   1   request valid
//   sram_wen   in   4   byte write enables (0 = read)
//   sram_addr  in  32   byte address ([1:0] ignored)
//   sram_wdata in  32   write data
//   sram_rdata out 32   registered read data
//   led        out 16   LED register
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led
);

    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_TIMER   = 16'hE000;
    localparam logic [15:0] OFF_SCRATCH = 16'hE004;

    // Replace the byte lanes of old_word selected by be with new_word's lanes.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return result;
    endfunction

    logic [31:0]       ram_r [0:2**ADDR_W-1];
    logic [31:0]       rdata_r;
    logic [15:0]       led_r;
    logic [31:0]       scratch_r;

    logic              mmio_sel_s;
    logic [ADDR_W-1:0] ram_idx_s;
    logic [31:0]       ram_merged_s;
    logic [31:0]       led_merged_s;
    logic [31:0]       scratch_merged_s;
    logic              ram_wr_s;
    logic              led_wr_s;
    logic              scratch_wr_s;
    logic              is_write_s;
    logic [31:0]       rd_next_s;

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0]       timer_r;
    logic [31:0]       timer_merged_s;
    logic              timer_wr_s;
`endif

    assign mmio_sel_s       = (sram_addr[31:16] == MMIO_HI);
    // Upper address bits above the RAM index are ignored, so RAM aliases.
    assign ram_idx_s        = sram_addr[ADDR_W+1:2];
    assign is_write_s       = sram_en && (sram_wen != 4'h0);
    assign ram_merged_s     = byte_merge(ram_r[ram_idx_s], sram_wdata, sram_wen);
    assign led_merged_s     = byte_merge({16'h0000, led_r}, sram_wdata, {2'b00, sram_wen[1:0]});
    assign scratch_merged_s = byte_merge(scratch_r, sram_wdata, sram_wen);
`ifdef SRAM_RESP_TIMER_EN
    assign timer_merged_s   = byte_merge(timer_r, sram_wdata, sram_wen);
`endif

    assign sram_rdata = rdata_r;
    assign led        = led_r;

    // Address decode: target write strobes and the next read-data value.
    always_comb begin
        rd_next_s    = 32'h0000_0000;
        ram_wr_s     = 1'b0;
        led_wr_s     = 1'b0;
        scratch_wr_s = 1'b0;
`ifdef SRAM_RESP_TIMER_EN
        timer_wr_s   = 1'b0;
`endif
        if (!mmio_sel_s) begin
            ram_wr_s  = is_write_s;
            rd_next_s = ram_merged_s;
        end else begin
            case (sram_addr[15:0])
                OFF_LED: begin
                    led_wr_s  = is_write_s;
                    rd_next_s = {16'h0000, led_merged_s[15:0]};
                end
                OFF_SCRATCH: begin
                    scratch_wr_s = is_write_s;
                    rd_next_s    = scratch_merged_s;
                end
`ifdef SRAM_RESP_TIMER_EN
                OFF_TIMER: begin
                    timer_wr_s = is_write_s;
                    // A plain read sees the pre-edge count; a write returns the loaded value.
                    rd_next_s  = timer_merged_s;
                end
`endif
                default: begin
                    rd_next_s = 32'h0000_0000;
                end
            endcase
        end
    end

    // RAM array: no reset so contents survive resetn; writes are dropped while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && ram_wr_s) begin
            ram_r[ram_idx_s] <= ram_merged_s;
        end
    end

    // Read-data, LED and scratch registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_r   <= 32'h0000_0000;
            led_r     <= 16'h0000;
            scratch_r <= 32'h0000_0000;
        end else begin
            if (sram_en) begin
                rdata_r <= rd_next_s;
            end
            if (led_wr_s) begin
                led_r <= led_merged_s[15:0];
            end
            if (scratch_wr_s) begin
                scratch_r <= scratch_merged_s;
            end
        end
    end

`ifdef SRAM_RESP_TIMER_EN
    // Free-running timer; a write takes priority over the increment for that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_r <= 32'h0000_0000;
        end else if (timer_wr_s) begin
            timer_r <= timer_merged_s;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end
`endif

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the CPU's SRAM-style data port. It accepts the enable, byte-write-enable, address and write-data signals driven by the core, and returns read data one cycle later. Requests decode to an on-chip word RAM or to a small MMIO register window: LED, free-running timer and scratch. It sits between the core's data port and the board/testbench, and can equally back the instruction port with byte-write-enables tied to zero.

## Interface
Parameters:
- `ADDR_W`, default 12: word-index width; RAM depth is 2^ADDR_W 32-bit words (16 KB at default).
- `MMIO_HI`, default 16'hBFAF: value of `sram_addr[31:16]` that selects the MMIO window.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `resetn`, input, 1: reset, asynchronous and active-low.
- `sram_en`, input, 1: request valid this cycle.
- `sram_wen`, input, 4: byte write enables; bit i writes `sram_wdata[8i+7:8i]`. A value of 0 means read.
- `sram_addr`, input, 32: byte address; bits [1:0] are ignored.
- `sram_wdata`, input, 32: write data.
- `sram_rdata`, output, 32: read data, registered.
- `led`, output, 16: LED register contents.

## Operation
- Decode:
  - MMIO when `sram_addr[31:16] == MMIO_HI`; otherwise RAM.
  - RAM index is `sram_addr[ADDR_W+1:2]`. Higher bits are ignored, so addresses alias with wrap-around.
- RAM write (`sram_en` high, `sram_wen != 0`): only the enabled bytes update at the edge; the other bytes keep their value.
- RAM read (`sram_en` high): `sram_rdata` loads the addressed word at the edge. On a write cycle, `sram_rdata` loads the merged post-write word (write-first).
- MMIO registers, selected by `sram_addr[15:0]`:
  - 16'hF000 LED: read/write, low 16 bits with byte enables [1:0]. Reads return {16'h0, led}.
  - 16'hE000 TIMER: 32-bit. Increments by 1 every cycle and wraps from 32'hFFFFFFFF to 0. A write loads the byte-enabled bytes of the current value; when a write and an increment coincide, the write wins for that cycle and counting resumes on the next cycle. A read returns the value before this edge.
  - 16'hE004 SCRATCH: 32-bit read/write with byte enables.
  - Any other offset: reads return 0; writes are ignored.
- Idle (`sram_en` low): no state change except the timer; `sram_rdata` holds its last value.
- Reset (`resetn` low, any time including mid-access):
  - `sram_rdata`, `led`, TIMER and SCRATCH clear to 0 immediately.
  - RAM contents are not reset and are preserved.
  - An access in flight during reset is discarded.
- After `resetn` rises, the first edge with `sram_en` high is serviced normally.

## Timing
- Read latency is 1 cycle: a request at edge N puts data on `sram_rdata` after edge N+1 (registered output).
- One request per cycle, no wait states and no back-pressure. Back-to-back reads to any mix of RAM and MMIO return in request order, one per cycle.
- Read-after-write to the same address in consecutive cycles returns the newly written data.
- `led` is registered and updates 1 cycle after the write edge.

## Configuration
- `SRAM_RESP_TIMER_EN` defined: TIMER is implemented as described.
- `SRAM_RESP_TIMER_EN` undefined:
  - No timer counter is synthesized.
  - Offset 16'hE000 behaves as unmapped: reads return 0 and writes are ignored.
  - LED, SCRATCH and RAM are unchanged.

## Test plan
- Reset value: assert `resetn`=0 mid-run → `sram_rdata`=0, `led`=0, and a read of TIMER right after release returns a value ≤ 2.
- Byte write: write 32'hAABBCCDD to 0x00000100 with wen=4'hF, then write 32'h11223344 with wen=4'b0101, then read → 32'hAA22CC44, valid exactly 1 cycle after the read request.
- Aliasing and wrap-around (ADDR_W=12): write 32'h5A5A5A5A to 0x00004000, read 0x00000000 → 32'h5A5A5A5A. Read 0x00003FFC after writing it → the written value.
- MMIO:
  - Write 32'h0000BEEF to 0xBFAFF000 → `led`=16'hBEEF one cycle later.
  - Read 0xBFAF1234 → 0.
  - Write and read back SCRATCH with wen=4'b1000 and data 32'hFF000000 → 32'hFF000000.
- Timer (macro defined):
  - Write 32'hFFFFFFFE, then read on the next two cycles → 32'hFFFFFFFE, then 32'hFFFFFFFF.
  - Read two cycles after that → 0x00000001 (wrap).
  - With the macro undefined, the same sequence reads 0 throughout.
- Read-after-write and idle hold:
  - Write 32'h12345678 to 0x80 and read 0x80 on the next cycle → 32'h12345678.
  - Then drop `sram_en` for 3 cycles → `sram_rdata` stays 32'h12345678.
